// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - core-wide widths, memory op encodings and LSU decode helpers
package core_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int MEM_CTRL_WIDTH = 4;
    localparam int BE_WIDTH       = DATA_WIDTH / 8;
    localparam int OFF_WIDTH      = $clog2(BE_WIDTH);

    typedef logic [MEM_CTRL_WIDTH-1:0] mem_ctrl_t;

    localparam mem_ctrl_t MEM_NONE = 4'd0;
    localparam mem_ctrl_t MEM_LB   = 4'd1;
    localparam mem_ctrl_t MEM_LH   = 4'd2;
    localparam mem_ctrl_t MEM_LW   = 4'd3;
    localparam mem_ctrl_t MEM_LD   = 4'd4;
    localparam mem_ctrl_t MEM_LBU  = 4'd5;
    localparam mem_ctrl_t MEM_LHU  = 4'd6;
    localparam mem_ctrl_t MEM_LWU  = 4'd7;
    localparam mem_ctrl_t MEM_SB   = 4'd8;
    localparam mem_ctrl_t MEM_SH   = 4'd9;
    localparam mem_ctrl_t MEM_SW   = 4'd10;
    localparam mem_ctrl_t MEM_SD   = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } lsu_state_e;

    // Unknown encodings and 64-bit-only ops on a 32-bit core behave as pass-through.
    function automatic mem_ctrl_t mem_normalize(input mem_ctrl_t ctrl);
        mem_ctrl_t r;
        r = ctrl;
        if (ctrl > MEM_SD) begin
            r = MEM_NONE;
        end
        if (DATA_WIDTH == 32 && (ctrl == MEM_LD || ctrl == MEM_LWU || ctrl == MEM_SD)) begin
            r = MEM_NONE;
        end
        return r;
    endfunction

    // log2 of access size in bytes
    function automatic logic [1:0] mem_size(input mem_ctrl_t ctrl);
        logic [1:0] s;
        case (ctrl)
            MEM_LH, MEM_LHU, MEM_SH: s = 2'd1;
            MEM_LW, MEM_LWU, MEM_SW: s = 2'd2;
            MEM_LD, MEM_SD:          s = 2'd3;
            default:                 s = 2'd0;
        endcase
        return s;
    endfunction

    function automatic logic mem_is_store(input mem_ctrl_t ctrl);
        return (ctrl == MEM_SB) || (ctrl == MEM_SH) || (ctrl == MEM_SW) || (ctrl == MEM_SD);
    endfunction

    function automatic logic mem_misaligned(input mem_ctrl_t ctrl, input logic [2:0] addr_lo);
        logic m;
        case (mem_size(ctrl))
            2'd1:    m = addr_lo[0] != 1'b0;
            2'd2:    m = addr_lo[1:0] != 2'b00;
            2'd3:    m = addr_lo != 3'b000;
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering for store data/enables and load extraction/extension
import core_pkg::*;

module lsu_align (
    input  mem_ctrl_t                ctrl,
    input  logic [OFF_WIDTH-1:0]     offset,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [DATA_WIDTH-1:0]    rdata,
    output logic [BE_WIDTH-1:0]      be,
    output logic [DATA_WIDTH-1:0]    wdata_lane,
    output logic [DATA_WIDTH-1:0]    rdata_ext
);

    logic [BE_WIDTH-1:0]   size_mask;
    logic [DATA_WIDTH-1:0] wdata_shift;
    logic [DATA_WIDTH-1:0] rdata_shift;
    logic [OFF_WIDTH+2:0]  shamt;

    assign shamt       = {offset, 3'b000};
    assign wdata_shift = wdata << shamt;
    assign rdata_shift = rdata >> shamt;
    assign be          = size_mask << offset;

    always_comb begin
        size_mask = '0;
        for (int i = 0; i < BE_WIDTH; i++) begin
            size_mask[i] = (i < (1 << mem_size(ctrl)));
        end
    end

    // Lanes outside the access are forced to zero rather than carrying upper wdata bytes.
    always_comb begin
        wdata_lane = '0;
        for (int i = 0; i < BE_WIDTH; i++) begin
            wdata_lane[8*i +: 8] = be[i] ? wdata_shift[8*i +: 8] : 8'h00;
        end
    end

    always_comb begin
        rdata_ext = rdata_shift;
        case (ctrl)
            MEM_LB:  rdata_ext = DATA_WIDTH'($signed(rdata_shift[7:0]));
            MEM_LBU: rdata_ext = DATA_WIDTH'(rdata_shift[7:0]);
            MEM_LH:  rdata_ext = DATA_WIDTH'($signed(rdata_shift[15:0]));
            MEM_LHU: rdata_ext = DATA_WIDTH'(rdata_shift[15:0]);
            MEM_LW:  rdata_ext = DATA_WIDTH'($signed(rdata_shift[31:0]));
            MEM_LWU: rdata_ext = DATA_WIDTH'(rdata_shift[31:0]);
            default: rdata_ext = rdata_shift;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: accepts one op, runs one bus transaction, holds result for writeback
import core_pkg::*;

module lsu (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [DATA_WIDTH-1:0]     addr_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    input  logic [MEM_CTRL_WIDTH-1:0] ctrl_i,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [DATA_WIDTH-1:0]     mem_addr_o,
    output logic [BE_WIDTH-1:0]       mem_be_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    input  logic                      mem_gnt_i,
    input  logic                      mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [DATA_WIDTH-1:0]     out_o,
    output logic                      misaligned_o
);

    lsu_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    mem_ctrl_t             ctrl_q;
    logic [DATA_WIDTH-1:0] out_q;
    logic                  misaligned_q;

    mem_ctrl_t             ctrl_n;
    logic                  mis_n;
    logic                  accept;
    logic                  in_req;

    logic [BE_WIDTH-1:0]   be_lane;
    logic [DATA_WIDTH-1:0] wdata_lane;
    logic [DATA_WIDTH-1:0] rdata_ext;

    assign ctrl_n  = mem_normalize(ctrl_i);
    assign mis_n   = mem_misaligned(ctrl_n, addr_i[2:0]);
    assign ready_o = (state_q == ST_IDLE) && rstn_i;
    assign accept  = valid_i && ready_o;
    assign in_req  = (state_q == ST_REQ);

    lsu_align u_align (
        .ctrl       (ctrl_q),
        .offset     (addr_q[OFF_WIDTH-1:0]),
        .wdata      (wdata_q),
        .rdata      (mem_rdata_i),
        .be         (be_lane),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext)
    );

    // Bus outputs come only from latched operands, so they cannot move while a grant is pending.
    assign mem_req_o    = in_req;
    assign mem_we_o     = in_req && mem_is_store(ctrl_q);
    assign mem_addr_o   = in_req ? {addr_q[DATA_WIDTH-1:OFF_WIDTH], {OFF_WIDTH{1'b0}}} : '0;
    assign mem_be_o     = in_req ? be_lane : '0;
    assign mem_wdata_o  = in_req ? wdata_lane : '0;
    assign valid_o      = (state_q == ST_RESP);
    assign out_o        = out_q;
    assign misaligned_o = misaligned_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (ctrl_n == MEM_NONE || mis_n) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem_gnt_i) begin
                    state_d = mem_is_store(ctrl_q) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid_i) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            ctrl_q       <= MEM_NONE;
            out_q        <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        addr_q       <= addr_i;
                        wdata_q      <= wdata_i;
                        ctrl_q       <= ctrl_n;
                        misaligned_q <= (ctrl_n != MEM_NONE) && mis_n;
                        if (ctrl_n == MEM_NONE) begin
                            out_q <= addr_i;
                        end else begin
                            out_q <= '0;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_gnt_i) begin
                        out_q <= '0;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid_i) begin
                        out_q <= rdata_ext;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - randomized and directed checks of lsu against a behavioural model
import core_pkg::*;

module tb_lsu;

    logic                      clk = 1'b0;
    logic                      rstn_i;
    logic                      valid_i;
    logic                      ready_o;
    logic [DATA_WIDTH-1:0]     addr_i;
    logic [DATA_WIDTH-1:0]     wdata_i;
    logic [MEM_CTRL_WIDTH-1:0] ctrl_i;
    logic                      mem_req_o;
    logic                      mem_we_o;
    logic [DATA_WIDTH-1:0]     mem_addr_o;
    logic [BE_WIDTH-1:0]       mem_be_o;
    logic [DATA_WIDTH-1:0]     mem_wdata_o;
    logic                      mem_gnt_i;
    logic                      mem_rvalid_i;
    logic [DATA_WIDTH-1:0]     mem_rdata_i;
    logic                      valid_o;
    logic                      ready_i;
    logic [DATA_WIDTH-1:0]     out_o;
    logic                      misaligned_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    lsu dut (
        .clk_i        (clk),
        .rstn_i       (rstn_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .ctrl_i       (ctrl_i),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .out_o        (out_o),
        .misaligned_o (misaligned_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Access size in bytes on a 32-bit core; 0 means the op passes addr_i through.
    function automatic int model_size(input logic [3:0] c);
        case (c)
            MEM_LB, MEM_LBU, MEM_SB: return 1;
            MEM_LH, MEM_LHU, MEM_SH: return 2;
            MEM_LW, MEM_SW:          return 4;
            default:                 return 0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [3:0] c, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int gnt_dly, input int rv_dly,
                          input int rdy_dly, output logic [31:0] got);
        int          sz;
        int          off;
        bit          mis;
        bit          st;
        bit          sgn;
        longint      v;
        logic [31:0] exp_out;
        logic [31:0] exp_wd;
        logic [3:0]  exp_be;

        sz  = model_size(c);
        off = int'(addr % 4);
        st  = (c == MEM_SB) || (c == MEM_SH) || (c == MEM_SW);
        sgn = (c == MEM_LB) || (c == MEM_LH) || (c == MEM_LW);
        mis = (sz != 0) && ((addr % sz) != 0);
        exp_be = 4'(((1 << sz) - 1) << off);
        exp_wd = '0;
        for (int b = 0; b < sz; b++) begin
            exp_wd = exp_wd | (((wdata >> (8 * b)) & 32'hFF) << (8 * (off + b)));
        end
        if (sz == 0) begin
            exp_out = addr;
        end else if (mis || st) begin
            exp_out = '0;
        end else begin
            v = longint'(rdata >> (8 * off));
            v = v & ((64'd1 << (8 * sz)) - 1);
            if (sgn && v >= (64'd1 << (8 * sz - 1))) begin
                v = v - (64'd1 << (8 * sz));
            end
            exp_out = v[31:0];
        end

        check("idle_ready", ready_o, 1);
        ctrl_i  = c;
        addr_i  = addr;
        wdata_i = wdata;
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        ctrl_i  = 4'($urandom);
        addr_i  = $urandom;
        wdata_i = $urandom;

        if (sz != 0 && !mis) begin
            for (int k = 0; k <= gnt_dly; k++) begin
                check("req", mem_req_o, 1);
                check("req_addr", mem_addr_o, addr & 32'hFFFF_FFFC);
                check("req_be", mem_be_o, exp_be);
                check("req_we", mem_we_o, st);
                check("req_ready", ready_o, 0);
                check("req_valid", valid_o, 0);
                if (st) check("req_wdata", mem_wdata_o, exp_wd);
                mem_rvalid_i = 1'($urandom_range(0, 1));
                mem_rdata_i  = $urandom;
                mem_gnt_i    = (k == gnt_dly);
                step();
                mem_gnt_i    = 1'b0;
                mem_rvalid_i = 1'b0;
            end
            check("req_drop", mem_req_o, 0);
            if (!st) begin
                for (int k = 0; k <= rv_dly; k++) begin
                    check("wait_valid", valid_o, 0);
                    if (k == rv_dly) begin
                        mem_rvalid_i = 1'b1;
                        mem_rdata_i  = rdata;
                    end
                    step();
                    mem_rvalid_i = 1'b0;
                    mem_rdata_i  = $urandom;
                end
            end
        end else begin
            check("no_req", mem_req_o, 0);
        end

        got = out_o;
        for (int k = 0; k <= rdy_dly; k++) begin
            check("resp_valid", valid_o, 1);
            check("resp_out", out_o, exp_out);
            check("resp_mis", misaligned_o, mis);
            check("resp_ready", ready_o, 0);
            ready_i = (k == rdy_dly);
            step();
            ready_i = 1'b0;
        end
        check("done_valid", valid_o, 0);
    endtask

    initial begin
        logic [31:0] got;
        logic [3:0]  c;
        logic [31:0] a;

        rstn_i = 1'b0;
        valid_i = 1'b0;
        addr_i = '0;
        wdata_i = '0;
        ctrl_i = MEM_NONE;
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i = '0;
        ready_i = 1'b0;
        step();
        step();
        check("rst_valid", valid_o, 0);
        check("rst_req", mem_req_o, 0);
        check("rst_we", mem_we_o, 0);
        check("rst_be", mem_be_o, 0);
        check("rst_addr", mem_addr_o, 0);
        check("rst_wdata", mem_wdata_o, 0);
        check("rst_out", out_o, 0);
        check("rst_mis", misaligned_o, 0);
        check("rst_ready", ready_o, 0);
        rstn_i = 1'b1;
        step();

        run_op(MEM_LB, 32'h1003, 32'h0, 32'h80AABBCC, 0, 0, 0, got);
        check("lb_value", got, 32'hFFFFFF80);
        run_op(MEM_LBU, 32'h1003, 32'h0, 32'h80AABBCC, 0, 0, 0, got);
        check("lbu_value", got, 32'h00000080);
        run_op(MEM_SH, 32'h1002, 32'h00001234, 32'h0, 0, 0, 0, got);
        run_op(MEM_LW, 32'h1001, 32'h0, 32'h0, 0, 0, 0, got);
        run_op(MEM_NONE, 32'hDEADBEEF, 32'h0, 32'h0, 0, 0, 3, got);
        check("none_value", got, 32'hDEADBEEF);
        run_op(MEM_SW, 32'h3004, 32'hCAFEF00D, 32'h0, 4, 0, 0, got);
        run_op(MEM_LD, 32'h2003, 32'h0, 32'h0, 0, 0, 0, got);
        run_op(MEM_LH, 32'h2002, 32'h0, 32'h8001_0000, 1, 2, 1, got);

        // Reset while waiting for read data; a following stray rvalid must be ignored.
        ctrl_i = MEM_LW;
        addr_i = 32'h2000;
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        rstn_i = 1'b0;
        step();
        check("wrst_valid", valid_o, 0);
        check("wrst_req", mem_req_o, 0);
        check("wrst_out", out_o, 0);
        check("wrst_be", mem_be_o, 0);
        check("wrst_ready", ready_o, 0);
        rstn_i = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i = 32'h12345678;
        step();
        mem_rvalid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("wrst_after_valid", valid_o, 0);
            check("wrst_after_ready", ready_o, 1);
            check("wrst_after_out", out_o, 0);
            step();
        end

        for (int n = 0; n < 150; n++) begin
            c = 4'($urandom_range(0, 15));
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            run_op(c, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 2),
                   $urandom_range(0, 2), got);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
